// File: rtl/right_shift_unit.sv
// Multi-cycle right shifter: logical or arithmetic shift by up to STEP bits per clock,
// with a Start/Busy/Done handshake. All outputs are registers.
module right_shift_unit #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEP  = 1
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic [WIDTH-1:0] In,
    input  logic [4:0]       Shamt,
    input  logic             Arith,
    output logic [WIDTH-1:0] Out,
    output logic             Busy,
    output logic             Done
);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    localparam logic [4:0] StepAmt = 5'(STEP);

    state_e           state_q;
    logic [WIDTH-1:0] work_q;
    logic [4:0]       rem_q;
    logic             fill_q;

    logic [4:0]       step_amt;
    logic [4:0]       rem_nxt;
    logic [WIDTH-1:0] fill_mask;
    logic [WIDTH-1:0] shift_res;

    // The final step may be shorter than STEP so the total never overshoots Shamt.
    always_comb begin
        step_amt  = (rem_q < StepAmt) ? rem_q : StepAmt;
        rem_nxt   = rem_q - step_amt;
        fill_mask = fill_q ? ~({WIDTH{1'b1}} >> step_amt) : '0;
        shift_res = (work_q >> step_amt) | fill_mask;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= StIdle;
            work_q  <= '0;
            rem_q   <= '0;
            fill_q  <= 1'b0;
            Out     <= '0;
            Busy    <= 1'b0;
            Done    <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (Start) begin
                        work_q <= In;
                        rem_q  <= Shamt;
                        fill_q <= Arith & In[WIDTH-1];
                        Busy   <= 1'b1;
                        if (Shamt == 5'd0) begin
                            Out     <= In;
                            Done    <= 1'b1;
                            state_q <= StDone;
                        end else begin
                            Done    <= 1'b0;
                            state_q <= StShift;
                        end
                    end else begin
                        Busy    <= 1'b0;
                        Done    <= 1'b0;
                        state_q <= StIdle;
                    end
                end
                StShift: begin
                    work_q <= shift_res;
                    rem_q  <= rem_nxt;
                    if (rem_nxt == 5'd0) begin
                        Out     <= shift_res;
                        Done    <= 1'b1;
                        state_q <= StDone;
                    end
                end
                default: begin
                    Busy    <= 1'b0;
                    Done    <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_right_shift_unit.sv
// Directed bench for right_shift_unit: three instances (STEP 1, 4, 16) share operand inputs
// and reset; each has its own Start. Expected results and latencies are hand-computed.
module tb_right_shift_unit;

    logic        clk;
    logic        reset;
    logic        start_w [3];
    logic [31:0] op_in;
    logic [4:0]  op_sh;
    logic        op_ar;
    logic [31:0] out_w [3];
    logic        busy_w [3];
    logic        done_w [3];

    int n_cmp;
    int n_err;

    right_shift_unit #(.WIDTH(32), .STEP(1)) u_s1 (
        .Clk(clk), .Reset(reset), .Start(start_w[0]), .In(op_in), .Shamt(op_sh),
        .Arith(op_ar), .Out(out_w[0]), .Busy(busy_w[0]), .Done(done_w[0])
    );
    right_shift_unit #(.WIDTH(32), .STEP(4)) u_s4 (
        .Clk(clk), .Reset(reset), .Start(start_w[1]), .In(op_in), .Shamt(op_sh),
        .Arith(op_ar), .Out(out_w[1]), .Busy(busy_w[1]), .Done(done_w[1])
    );
    right_shift_unit #(.WIDTH(32), .STEP(16)) u_s16 (
        .Clk(clk), .Reset(reset), .Start(start_w[2]), .In(op_in), .Shamt(op_sh),
        .Arith(op_ar), .Out(out_w[2]), .Busy(busy_w[2]), .Done(done_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Called just after the accept edge; returns edges until Done and Busy-high samples.
    task automatic wait_done(input int u, input string tag, output int lat, output int bcnt);
        bit seen;
        lat  = 0;
        bcnt = 0;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (busy_w[u]) bcnt++;
            if (done_w[u]) begin
                seen = 1;
                break;
            end
            @(posedge clk);
            #1;
            lat++;
        end
        if (!seen) check({tag, " timeout"}, 32'(done_w[u]), 32'd1);
    endtask

    task automatic run_op(input int u, input logic [31:0] a, input logic [4:0] sh,
                          input logic ar, input logic [31:0] exp_out, input int exp_lat,
                          input string tag);
        int lat;
        int bc;
        @(negedge clk);
        op_in      = a;
        op_sh      = sh;
        op_ar      = ar;
        start_w[u] = 1'b1;
        @(posedge clk);
        #1;
        start_w[u] = 1'b0;
        wait_done(u, tag, lat, bc);
        check({tag, " out"}, out_w[u], exp_out);
        check({tag, " lat"}, 32'(lat), 32'(exp_lat));
        check({tag, " busy"}, 32'(bc), 32'(exp_lat + 1));
        @(posedge clk);
        #1;
        check({tag, " done width"}, 32'(done_w[u]), 32'd0);
        check({tag, " idle"}, 32'(busy_w[u]), 32'd0);
        check({tag, " hold"}, out_w[u], exp_out);
    endtask

    initial begin
        int lat;
        int bc;
        int dcnt;
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        for (int i = 0; i < 3; i++) start_w[i] = 1'b0;
        op_in = 32'h0;
        op_sh = 5'd0;
        op_ar = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset out", out_w[i], 32'h0);
            check("reset busy", 32'(busy_w[i]), 32'd0);
            check("reset done", 32'(done_w[i]), 32'd0);
        end
        reset = 1'b0;

        run_op(0, 32'h8000_0010, 5'd4, 1'b0, 32'h0800_0001, 4, "s1 srl4");
        run_op(0, 32'h8000_0010, 5'd4, 1'b1, 32'hF800_0001, 4, "s1 sra4");
        run_op(0, 32'h1234_ABCD, 5'd0, 1'b0, 32'h1234_ABCD, 0, "s1 sh0");
        run_op(0, 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 31, "s1 sra31");
        run_op(0, 32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 31, "s1 srl31");
        run_op(2, 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 2, "s16 sra31");
        run_op(2, 32'h8000_0000, 5'd31, 1'b0, 32'h0000_0001, 2, "s16 srl31");
        run_op(2, 32'h1234_5678, 5'd17, 1'b0, 32'h0000_091A, 2, "s16 srl17");
        run_op(2, 32'hF000_0000, 5'd5, 1'b1, 32'hFF80_0000, 1, "s16 sra5");
        run_op(1, 32'hF000_0000, 5'd5, 1'b1, 32'hFF80_0000, 2, "s4 sra5");
        run_op(1, 32'h8000_0000, 5'd31, 1'b1, 32'hFFFF_FFFF, 8, "s4 sra31");
        run_op(1, 32'h7FFF_FFFF, 5'd3, 1'b1, 32'h0FFF_FFFF, 1, "s4 sra3 pos");

        // Start mid-SHIFT is ignored, then Start held in DONE is accepted back-to-back.
        @(negedge clk);
        op_in = 32'h0000_FF00;
        op_sh = 5'd8;
        op_ar = 1'b0;
        start_w[0] = 1'b1;
        @(posedge clk);
        #1;
        start_w[0] = 1'b0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        op_in = 32'hFFFF_FFFF;
        op_sh = 5'd1;
        op_ar = 1'b1;
        start_w[0] = 1'b1;
        @(posedge clk);
        #1;
        start_w[0] = 1'b0;
        wait_done(0, "midshift", lat, bc);
        check("midshift lat", 32'(lat + 4), 32'd8);
        check("midshift out", out_w[0], 32'h0000_00FF);
        op_in = 32'h8000_0001;
        op_sh = 5'd1;
        op_ar = 1'b1;
        start_w[0] = 1'b1;
        @(posedge clk);
        #1;
        start_w[0] = 1'b0;
        check("b2b done low", 32'(done_w[0]), 32'd0);
        check("b2b busy", 32'(busy_w[0]), 32'd1);
        check("b2b out held", out_w[0], 32'h0000_00FF);
        @(posedge clk);
        #1;
        check("b2b done", 32'(done_w[0]), 32'd1);
        check("b2b out", out_w[0], 32'hC000_0000);
        @(posedge clk);
        #1;
        check("b2b done width", 32'(done_w[0]), 32'd0);

        // Reset at edge k+2 of a Shamt=10 op aborts it.
        @(negedge clk);
        op_in = 32'hFFFF_FFFF;
        op_sh = 5'd10;
        op_ar = 1'b0;
        start_w[0] = 1'b1;
        @(posedge clk);
        #1;
        start_w[0] = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort busy", 32'(busy_w[0]), 32'd0);
        check("abort done", 32'(done_w[0]), 32'd0);
        check("abort out", out_w[0], 32'h0);
        dcnt = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done_w[0]) dcnt++;
        end
        check("abort no done", 32'(dcnt), 32'd0);
        run_op(0, 32'hFFFF_FFFF, 5'd10, 1'b0, 32'h003F_FFFF, 10, "s1 after abort");

        // Reset and Start in the same cycle: reset wins.
        @(negedge clk);
        op_in = 32'h1234_5678;
        op_sh = 5'd0;
        start_w[0] = 1'b1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        start_w[0] = 1'b0;
        reset = 1'b0;
        check("rst+start busy", 32'(busy_w[0]), 32'd0);
        check("rst+start done", 32'(done_w[0]), 32'd0);
        check("rst+start out", out_w[0], 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
